// File: rtl/reset_board_pkg.sv
// Shared types and constants for the board-reset sequencer: FSM state encoding,
// board size and the 4-bit tile codes held in the initial-board ROM.
package reset_board_pkg;

    localparam int NUM_CELLS      = 768;
    localparam int PELLET_COUNT_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_CAPTURE,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [3:0] TILE_EMPTY  = 4'd0;
    localparam logic [3:0] TILE_WALL   = 4'd1;
    localparam logic [3:0] TILE_PELLET = 4'd2;
    localparam logic [3:0] TILE_POWER  = 4'd3;

    // Both pellet kinds count toward the win-condition total.
    function automatic logic is_pellet_tile(input logic [3:0] tile);
        return (tile == TILE_PELLET) || (tile == TILE_POWER);
    endfunction

endpackage

// File: rtl/reset_board_pellet_counter.sv
// Counts pellet and power-pellet tiles as they are written into the board RAM.
// Only instantiated when RESET_BOARD_PELLET_COUNT_EN is defined.
module reset_board_pellet_counter
    import reset_board_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic [3:0]                tile,
    output logic [PELLET_COUNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wr_en && is_pellet_tile(tile)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/reset_board_controller.sv
// Sequences the reset-board datapath to copy all initial tiles into the shared board RAM.
// Optional pellet_count output is built when RESET_BOARD_PELLET_COUNT_EN is defined.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for start; all outputs low
//   LOAD     | clear overwrite address, claim the RAM write port
//   FETCH    | wait ROM_LATENCY cycles for ROM q, or finish at last address
//   CAPTURE  | latch ROM q into initial_data
//   WRITE    | write cell and advance address; stalls while ram_gnt is low
//   DONE     | one-cycle completion pulse, RAM port released
module reset_board_controller
    import reset_board_pkg::*;
#(
    parameter int ROM_LATENCY = 1,
    parameter int NUM_CELLS   = 768
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       last_addr_reached,
    input  logic [3:0] initial_data,
    input  logic       ram_gnt,
    output logic       load,
    output logic       get_data,
    output logic       incr,
    output logic       board_wr_en,
    output logic       ram_req,
    output logic       busy,
    output logic       done
`ifdef RESET_BOARD_PELLET_COUNT_EN
    ,
    output logic [PELLET_COUNT_W-1:0] pellet_count
`endif
);

    localparam logic [1:0] LAT_RELOAD = 2'(ROM_LATENCY - 1);

    if (ROM_LATENCY < 1 || ROM_LATENCY > 3) begin : g_bad_latency
        $error("ROM_LATENCY must be within 1..3");
    end

    state_t     state;
    state_t     state_nxt;
    logic [1:0] lat_cnt;
    logic [1:0] lat_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        load        = 1'b0;
        get_data    = 1'b0;
        incr        = 1'b0;
        board_wr_en = 1'b0;
        ram_req     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load        = 1'b1;
                ram_req     = 1'b1;
                state_nxt   = ST_FETCH;
                lat_cnt_nxt = LAT_RELOAD;
            end
            ST_FETCH: begin
                ram_req = 1'b1;
                // The end-of-board check wins over the ROM wait so the sweep ends promptly.
                if (last_addr_reached) begin
                    state_nxt = ST_DONE;
                end else if (lat_cnt == 2'd0) begin
                    state_nxt = ST_CAPTURE;
                end else begin
                    lat_cnt_nxt = lat_cnt - 2'd1;
                end
            end
            ST_CAPTURE: begin
                get_data  = 1'b1;
                ram_req   = 1'b1;
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                ram_req = 1'b1;
                // Write and increment share an edge: the RAM samples the old address.
                if (ram_gnt) begin
                    board_wr_en = 1'b1;
                    incr        = 1'b1;
                    state_nxt   = ST_FETCH;
                    lat_cnt_nxt = LAT_RELOAD;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef RESET_BOARD_PELLET_COUNT_EN
    if (NUM_CELLS >= (1 << PELLET_COUNT_W)) begin : g_bad_count_width
        $error("pellet_count is too narrow for NUM_CELLS");
    end

    reset_board_pellet_counter u_pellet_counter (
        .clk   (clk),
        .reset (reset),
        .clear (load),
        .wr_en (board_wr_en),
        .tile  (initial_data),
        .count (pellet_count)
    );
`else
    logic unused_inputs;
    assign unused_inputs = ^{initial_data, NUM_CELLS[0]};
`endif

endmodule

// File: tb/tb_reset_board_controller.sv
// Self-checking bench for reset_board_controller: one instance at ROM_LATENCY=1 and one at 2,
// driven through a behavioural reset-board datapath, ROM and board RAM model.
module tb_reset_board_controller;

    localparam int CELLS = 768;

    typedef struct {
        int    dut;
        int    stall_at;
        int    stall_len;
        int    rst_at;
        int    busy_at;
        int    exp_cycles;
        int    exp_writes;
        string name;
    } case_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] start;
    logic [1:0] gnt;
    logic [1:0] last_addr;
    logic [1:0] load, get_data, incr, wr_en, req, busy, done;
    logic [1:0] ram_clr;
    logic [3:0] idata [2] = '{4'd0, 4'd0};
    int         addr [2] = '{0, 0};
    logic [3:0] rom [CELLS];
    logic [3:0] ram [2][CELLS];
    int         exp_q [$];
    int         vectors = 0;
    int         miscompares = 0;
`ifdef RESET_BOARD_PELLET_COUNT_EN
    logic [9:0] pc0, pc1;
`endif

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 2; i++) last_addr[i] = (addr[i] == CELLS);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (load[i]) addr[i] <= 0;
            else if (incr[i]) addr[i] <= addr[i] + 1;
            if (get_data[i] && addr[i] < CELLS) idata[i] <= rom[addr[i]];
            if (ram_clr[i]) begin
                for (int a = 0; a < CELLS; a++) ram[i][a] <= 4'hF;
            end else if (wr_en[i] && addr[i] < CELLS) begin
                ram[i][addr[i]] <= idata[i];
            end
        end
    end

    reset_board_controller #(.ROM_LATENCY(1), .NUM_CELLS(CELLS)) u_lat1 (
        .clk(clk), .reset(reset), .start(start[0]), .last_addr_reached(last_addr[0]),
        .initial_data(idata[0]), .ram_gnt(gnt[0]), .load(load[0]), .get_data(get_data[0]),
        .incr(incr[0]), .board_wr_en(wr_en[0]), .ram_req(req[0]), .busy(busy[0]), .done(done[0])
`ifdef RESET_BOARD_PELLET_COUNT_EN
        , .pellet_count(pc0)
`endif
    );

    reset_board_controller #(.ROM_LATENCY(2), .NUM_CELLS(CELLS)) u_lat2 (
        .clk(clk), .reset(reset), .start(start[1]), .last_addr_reached(last_addr[1]),
        .initial_data(idata[1]), .ram_gnt(gnt[1]), .load(load[1]), .get_data(get_data[1]),
        .incr(incr[1]), .board_wr_en(wr_en[1]), .ram_req(req[1]), .busy(busy[1]), .done(done[1])
`ifdef RESET_BOARD_PELLET_COUNT_EN
        , .pellet_count(pc1)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int outs(input int d);
        return int'({load[d], get_data[d], incr[d], wr_en[d], req[d], busy[d], done[d]});
    endfunction

`ifdef RESET_BOARD_PELLET_COUNT_EN
    function automatic int pellets(input int d);
        return (d == 0) ? int'(pc0) : int'(pc1);
    endfunction
`endif

    task automatic run_case(input case_t c);
        int d          = c.dut;
        int lat        = c.dut + 1;
        int cyc        = 1;
        int writes     = 0;
        int dones      = 0;
        int done_cyc   = -1;
        int stall_left = 0;
        int chg        = -1;
        int bad_cells  = 0;
        bit finished   = 1'b0;
        bit prev_done  = 1'b0;
        bit was_reset  = 1'b0;

        exp_q.delete();
        for (int a = 0; a < CELLS; a++) exp_q.push_back(a);
        ram_clr[d] = 1'b1;
        @(posedge clk); #1;
        ram_clr[d] = 1'b0;
        start[d] = 1'b1;
        @(posedge clk); #1;

        while (!finished && cyc < 4000) begin
            start[d] = 1'b0;
            gnt[d]   = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                check({c.name, " stall_wr"}, int'(wr_en[d]), 0);
                check({c.name, " stall_incr"}, int'(incr[d]), 0);
                stall_left--;
            end
            if (get_data[d]) begin
                check({c.name, " get_data_latency"}, cyc - chg, lat + 1);
                if (addr[d] == c.stall_at) stall_left = c.stall_len;
            end
            if (load[d] || incr[d]) chg = cyc;
            if (prev_done) begin
                check({c.name, " busy_after_done"}, int'(busy[d]), 0);
                check({c.name, " no_restart"}, int'(load[d]), 0);
                finished = 1'b1;
            end
            if (done[d]) begin
                dones++;
                done_cyc = cyc;
`ifdef RESET_BOARD_PELLET_COUNT_EN
                check({c.name, " pellets_at_done"}, pellets(d), 244);
`endif
                if (c.busy_at >= 0) start[d] = 1'b1;
            end
            prev_done = done[d];
            if (wr_en[d]) begin
                writes++;
                check({c.name, " wr_addr"}, addr[d], (exp_q.size() > 0) ? exp_q.pop_front() : -1);
                if (addr[d] == c.busy_at) start[d] = 1'b1;
                if (addr[d] == c.rst_at) begin
                    reset = 1'b1;
                    @(posedge clk); #2;
                    reset = 1'b0;
                    check({c.name, " outputs_after_reset"}, outs(d), 0);
`ifdef RESET_BOARD_PELLET_COUNT_EN
                    check({c.name, " pellets_after_reset"}, pellets(d), 0);
`endif
                    was_reset = 1'b1;
                    finished  = 1'b1;
                end
            end
            if (!finished) begin
                @(posedge clk); #1;
                cyc++;
            end
        end

        start[d] = 1'b0;
        gnt[d]   = 1'b1;
        check({c.name, " completed_in_budget"}, int'(finished), 1);
        check({c.name, " write_count"}, writes, c.exp_writes);
        if (was_reset) begin
            check({c.name, " done_pulses"}, dones, 0);
        end else begin
            check({c.name, " done_pulses"}, dones, 1);
            check({c.name, " done_cycle"}, done_cyc, c.exp_cycles);
            check({c.name, " cells_unwritten"}, exp_q.size(), 0);
            for (int a = 0; a < CELLS; a++) if (ram[d][a] !== rom[a]) bad_cells++;
            check({c.name, " ram_vs_rom"}, bad_cells, 0);
            repeat (5) @(posedge clk);
            #1;
            check({c.name, " idle_outputs"}, outs(d), 0);
`ifdef RESET_BOARD_PELLET_COUNT_EN
            check({c.name, " pellets_hold"}, pellets(d), 244);
`endif
        end
    endtask

    case_t cases [6];

    initial begin
        for (int a = 0; a < CELLS; a++) begin
            if (a % 3 == 0 && a < 720) rom[a] = 4'd2;
            else if (a == 1 || a == 301 || a == 601 || a == 767) rom[a] = 4'd3;
            else if (a % 2 == 0) rom[a] = 4'd1;
            else rom[a] = 4'd0;
        end

        cases[0] = '{0, -1, 0, -1, -1, 2307, 768, "nominal"};
        cases[1] = '{0, 100, 10, -1, -1, 2317, 768, "grant_stall"};
        cases[2] = '{0, -1, 0, 400, -1, -1, 401, "reset_mid"};
        cases[3] = '{0, -1, 0, -1, -1, 2307, 768, "after_reset"};
        cases[4] = '{0, -1, 0, -1, 50, 2307, 768, "start_busy"};
        cases[5] = '{1, -1, 0, -1, -1, 3075, 768, "latency2"};

        reset   = 1'b1;
        start   = 2'b00;
        gnt     = 2'b11;
        ram_clr = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_lat1", outs(0), 0);
        check("reset_outputs_lat2", outs(1), 0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            gnt = 2'(k);
            @(posedge clk); #1;
            check("idle_gnt_ignored", outs(0) | outs(1), 0);
        end
        gnt = 2'b11;

        for (int i = 0; i < 6; i++) run_case(cases[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reset_board_controller.md
Name: reset_board_controller

Overview:
- FSM that sequences the board-reset datapath: address load, ROM-data capture and address increment.
- Writes each of the 768 initial tiles (32x24 board) into the board RAM.
- Board RAM write port is shared with game logic; the block holds it through a req/gnt handshake and stalls while the grant is low.
- Sits between the top-level game FSM (start/done) and the reset-board datapath plus board RAM.

Parameters:
- ROM_LATENCY, 1, cycles from overwrite address change to valid ROM q; legal range 1-3.
- NUM_CELLS, 768, board cell count; used only for the optional counter width check.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- start  input  1  single-cycle request to reinitialise the board; sampled only in IDLE
- last_addr_reached  input  1  from datapath; high when overwrite address == 768
- initial_data  input  4  tile code latched by datapath (used by optional feature)
- ram_gnt  input  1  board RAM write port granted to this block
- load  output  1  datapath: overwrite address <= 0
- get_data  output  1  datapath: latch ROM q into initial_data
- incr  output  1  datapath: overwrite address += 1
- board_wr_en  output  1  board RAM write enable (addr/data come from datapath)
- ram_req  output  1  request for board RAM write port
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at completion

Behaviour:
- States: IDLE, LOAD, FETCH, CAPTURE, WRITE, DONE.
- Reset (any cycle, including mid-operation): state <= IDLE, latency counter <= 0; all outputs 0 the next cycle. The datapath address is not cleared by this block, and a partial board is left as-is.
- IDLE: outputs 0. If start=1, go to LOAD. Otherwise stay.
- LOAD: load=1, ram_req=1. Next state FETCH; latency counter <= ROM_LATENCY-1.
- FETCH: ram_req=1.
  - If last_addr_reached=1, go to DONE. This check takes priority over the latency wait.
  - Else if counter==0, go to CAPTURE.
  - Else decrement the counter.
- CAPTURE: get_data=1, ram_req=1. Next state WRITE.
- WRITE: ram_req=1.
  - If ram_gnt=1: board_wr_en=1 and incr=1 in the same cycle (RAM samples the old address at that edge). Next state FETCH; counter <= ROM_LATENCY-1.
  - If ram_gnt=0: no write, no incr, stay in WRITE. Data and address are held.
- DONE: done=1, ram_req=0, busy=1. Next state IDLE unconditionally.
- Control outputs are combinational decodes of state and ram_gnt; there is no extra register latency.
- ram_req is high in LOAD, FETCH, CAPTURE and WRITE, and 0 in IDLE and DONE.
- ram_gnt is ignored outside WRITE. A grant that drops mid-sweep only stalls WRITE; no cell is skipped or written twice.
- start while busy (any non-IDLE state, including DONE) is ignored and not queued.
- Timing, ROM_LATENCY=1 and gnt held high: LOAD 1 cycle, then 3 cycles per cell (FETCH, CAPTURE, WRITE), then a final FETCH, then DONE. done is high in the 2307th cycle after the edge that samples start. Each extra latency cycle adds 1 cycle per cell.
- Exactly 768 board_wr_en pulses per completed sweep.

Optional Feature:
- Macro: RESET_BOARD_PELLET_COUNT_EN.
- Enabled: adds output pellet_count (10 bits).
  - Cleared in LOAD.
  - Increments on each board_wr_en cycle where initial_data is TILE_PELLET or TILE_POWER.
  - Holds its value after DONE until the next LOAD; reset clears it to 0.
  - Game logic uses it as the win-condition total.
- Disabled: port and logic absent; all other behaviour identical.

Decomposition:
- Package reset_board_pkg: state enum (6 states); NUM_CELLS=768; 4-bit tile codes TILE_EMPTY, TILE_WALL, TILE_PELLET, TILE_POWER.
- One natural sub-module, reset_board_pellet_counter, instantiated only under the macro.
- Latency counter stays inline.

Test Plan:
- Nominal sweep: reset, then start pulse with gnt=1 and ROM_LATENCY=1 -> 768 board_wr_en pulses at addresses 0..767 in order; done high for exactly one cycle, 2307 cycles after start; busy low the next cycle.
- Grant stall: drop ram_gnt for 10 cycles while in WRITE at address 100 -> no write and no incr during the stall; address 100 written exactly once after gnt returns; done delayed by exactly 10 cycles.
- Reset mid-sweep: assert reset at address 400 -> next cycle all outputs 0 and state IDLE. A new start produces LOAD and a full 768-write sweep from address 0.
- start while busy: pulse start at address 50, and again during the DONE cycle -> no restart; total writes remain 768; only one done pulse.
- ROM_LATENCY=2 -> each cell takes 4 cycles; get_data asserted 2 cycles after the address changes; done 3075 cycles after start.
- With RESET_BOARD_PELLET_COUNT_EN and a ROM image of 240 pellet + 4 power tiles -> pellet_count = 244 at done, and it holds that value until the next start.
